winograd_tile_sched: RTL and testbench

Sequencer for the 4x4 Winograd input-transform datapath, the top_B_x_B instance (per-lane 6-phase frame, 4 input vectors, outputs in phases 2..5).
- Accepts a stream of 4-lane input vectors from the feature-map buffer.
- Gathers them into tiles in a ping-pong buffer.
- Launches each tile into the datapath aligned to its frame.
- Gates the datapath's synchronous rst so frames start only when a full tile is ready.
- Tags transformed outputs with tile/column indices and signals job completion.

---
 rtl/winograd_pkg.sv | 17 +
 rtl/tile_pingpong_buf.sv | 56 +++++
 rtl/winograd_tile_sched.sv | 152 +++++++++++++++
 tb/tb_winograd_tile_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// Shared constants and types for the Winograd input-transform tile scheduler.
// Phase numbering follows the datapath's 6-cycle per-lane frame.
package winograd_pkg;

    localparam int unsigned W         = 32;
    localparam int unsigned TILE_LEN  = 4;
    localparam int unsigned FRAME_LEN = 6;

    localparam logic [2:0] PH_OUT_FIRST = 3'd2;
    localparam logic [2:0] PH_LAST_IN   = 3'(TILE_LEN - 1);
    localparam logic [2:0] PH_LAST      = 3'(FRAME_LEN - 1);

    typedef logic [TILE_LEN*W-1:0] vec_t;

    typedef enum logic [1:0] {StIdle, StRun, StFinish} job_state_e;

endpackage

// File: rtl/tile_pingpong_buf.sv
// Two-bank tile buffer: one bank fills column by column while the other is read out.
// A bank becomes full after its fourth column and stays full until released.
module tile_pingpong_buf
    import winograd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [TILE_LEN*W-1:0] wr_data,
    output logic                  wr_full,
    input  logic                  rd_release,
    input  logic [1:0]            rd_col,
    output logic [TILE_LEN*W-1:0] rd_data,
    output logic                  rd_full
);

    vec_t       mem [2][TILE_LEN];
    logic [1:0] full_q;
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] wr_col_q;

    // Writes only target a non-full bank and releases only a full one, so the
    // two full_q updates below never collide on the same bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q   <= 2'b00;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            wr_col_q <= 2'd0;
        end else begin
            if (wr_en) begin
                wr_col_q <= wr_col_q + 2'd1;
                if (wr_col_q == 2'(TILE_LEN - 1)) begin
                    full_q[wr_ptr_q] <= 1'b1;
                    wr_ptr_q         <= ~wr_ptr_q;
                end
            end
            if (rd_release) begin
                full_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q][wr_col_q] <= wr_data;
        end
    end

    assign wr_full = full_q[wr_ptr_q];
    assign rd_full = full_q[rd_ptr_q];
    assign rd_data = mem[rd_ptr_q][rd_col];

endmodule

// File: rtl/winograd_tile_sched.sv
// Sequencer for the 4x4 Winograd input-transform datapath: gathers input tiles,
// launches them frame-aligned into the datapath and tags the transformed columns.
module winograd_tile_sched #(
    parameter int unsigned W   = winograd_pkg::W,
    parameter int unsigned TCW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [TCW-1:0] num_tiles,
    output logic           busy,
    output logic           done,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [4*W-1:0] in_data,
    output logic           dp_rst,
    output logic [W-1:0]   dp_x1,
    output logic [W-1:0]   dp_x2,
    output logic [W-1:0]   dp_x3,
    output logic [W-1:0]   dp_x4,
    input  logic [W-1:0]   dp_r1,
    input  logic [W-1:0]   dp_r2,
    input  logic [W-1:0]   dp_r3,
    input  logic [W-1:0]   dp_r4,
    output logic           out_valid,
    output logic [4*W-1:0] out_data,
    output logic [1:0]     out_col,
    output logic [TCW-1:0] out_tile
);

    import winograd_pkg::*;

    job_state_e     state_q, state_d;
    logic [TCW-1:0] tiles_q;
    logic [TCW-1:0] rd_tile_q;
    logic [TCW+1:0] acc_q;
    logic [2:0]     ph_q;
    logic           done_q;
    logic           out_valid_q;
    logic [4*W-1:0] out_data_q;
    logic [1:0]     out_col_q;
    logic [TCW-1:0] out_tile_q;

    logic           start_job;
    logic           zero_job;
    logic           last_frame;
    logic           launch;
    logic           transfer;
    logic           release_bank;
    logic           wr_full;
    logic           rd_full;
    logic [4*W-1:0] rd_data;
    logic [4*W-1:0] dp_vec;

    assign start_job  = start && (state_q == StIdle);
    assign zero_job   = start_job && (num_tiles == '0);
    assign last_frame = (ph_q == PH_LAST) && (rd_tile_q == tiles_q - TCW'(1));
    assign transfer   = in_valid && in_ready;

    tile_pingpong_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (transfer),
        .wr_data    (in_data),
        .wr_full    (wr_full),
        .rd_release (release_bank),
        .rd_col     (ph_q[1:0]),
        .rd_data    (rd_data),
        .rd_full    (rd_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_job && !zero_job) state_d = StRun;
            StRun:    if (last_frame) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // The datapath is held in its state 0 (dp_rst low) until a full tile sits in
    // the read bank, so every frame starts with column 0 on dp_x.
    always_comb begin
        busy         = (state_q != StIdle);
        launch       = (state_q == StRun) && (ph_q == 3'd0) && rd_full;
        dp_rst       = (ph_q != 3'd0) || launch;
        in_ready     = (state_q == StRun) && !wr_full && (acc_q < {tiles_q, 2'b00});
        release_bank = (ph_q == PH_LAST_IN);
        dp_vec       = '0;
        if (dp_rst && !ph_q[2]) begin
            dp_vec = rd_data;
        end
    end

    assign dp_x1 = dp_vec[W-1:0];
    assign dp_x2 = dp_vec[2*W-1:W];
    assign dp_x3 = dp_vec[3*W-1:2*W];
    assign dp_x4 = dp_vec[4*W-1:3*W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tiles_q     <= '0;
            rd_tile_q   <= '0;
            acc_q       <= '0;
            ph_q        <= 3'd0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_col_q   <= 2'd0;
            out_tile_q  <= '0;
        end else begin
            done_q <= (state_q == StFinish) || zero_job;
            if (start_job) begin
                tiles_q   <= num_tiles;
                acc_q     <= '0;
                rd_tile_q <= '0;
            end else begin
                if (transfer) begin
                    acc_q <= acc_q + (TCW+2)'(1);
                end
                if (dp_rst && (ph_q == PH_LAST)) begin
                    rd_tile_q <= rd_tile_q + TCW'(1);
                end
            end
            if (dp_rst) begin
                ph_q <= (ph_q == PH_LAST) ? 3'd0 : ph_q + 3'd1;
            end
            out_valid_q <= (ph_q >= PH_OUT_FIRST);
            if (ph_q >= PH_OUT_FIRST) begin
                out_data_q <= {dp_r4, dp_r3, dp_r2, dp_r1};
                out_col_q  <= ph_q[1:0] + 2'd2;
                out_tile_q <= rd_tile_q;
            end
        end
    end

    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_col   = out_col_q;
    assign out_tile  = out_tile_q;

endmodule

// File: tb/tb_winograd_tile_sched.sv
// Bench for winograd_tile_sched: a behavioural 6-phase datapath plus a B^T X B
// reference model and expected-output queue.
module tb_winograd_tile_sched;

    localparam int W   = 32;
    localparam int TCW = 16;

    typedef logic [15:0][W-1:0] mat_t;  // index = column*4 + lane
    typedef struct packed {
        logic [4*W-1:0] data;
        logic [1:0]     col;
        logic [TCW-1:0] tile;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [TCW-1:0] num_tiles;
    logic           busy, done, in_valid, in_ready, dp_rst, out_valid;
    logic [4*W-1:0] in_data, out_data;
    logic [W-1:0]   dp_x1, dp_x2, dp_x3, dp_x4;
    logic [W-1:0]   dp_r1, dp_r2, dp_r3, dp_r4;
    logic [1:0]     out_col;
    logic [TCW-1:0] out_tile;

    winograd_tile_sched #(.W(W), .TCW(TCW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_tiles (num_tiles),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .dp_rst    (dp_rst),
        .dp_x1     (dp_x1),
        .dp_x2     (dp_x2),
        .dp_x3     (dp_x3),
        .dp_x4     (dp_x4),
        .dp_r1     (dp_r1),
        .dp_r2     (dp_r2),
        .dp_r3     (dp_r3),
        .dp_r4     (dp_r4),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_tile  (out_tile)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // R = B^T X B with the F(2,3) input-transform matrix.
    function automatic mat_t xform(input mat_t x);
        int   bt [4][4];
        mat_t r;
        int   acc;
        bt = '{'{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}};
        r = '0;
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 0;
                for (int k = 0; k < 4; k++)
                    for (int m = 0; m < 4; m++)
                        acc += bt[i][k] * bt[j][m] * int'(x[m*4+k]);
                r[j*4+i] = acc;
            end
        end
        return r;
    endfunction

    // Datapath model: state follows dp_rst, captures columns in states 0..3 and
    // presents output column s-2 in states 2..5.
    int   s = 0;
    mat_t dcols = '0;
    mat_t dview, dres;

    always @(posedge clk) begin
        if (!dp_rst) begin
            s <= 0;
        end else begin
            if (s < 4) begin
                dcols[s*4+0] <= dp_x1;
                dcols[s*4+1] <= dp_x2;
                dcols[s*4+2] <= dp_x3;
                dcols[s*4+3] <= dp_x4;
            end
            s <= (s == 5) ? 0 : s + 1;
        end
    end

    always_comb begin
        dview = dcols;
        if (s < 4) begin
            dview[s*4+0] = dp_x1;
            dview[s*4+1] = dp_x2;
            dview[s*4+2] = dp_x3;
            dview[s*4+3] = dp_x4;
        end
        dres  = xform(dview);
        dp_r1 = '0;
        dp_r2 = '0;
        dp_r3 = '0;
        dp_r4 = '0;
        if (s >= 2) begin
            dp_r1 = dres[(s-2)*4+0];
            dp_r2 = dres[(s-2)*4+1];
            dp_r3 = dres[(s-2)*4+2];
            dp_r4 = dres[(s-2)*4+3];
        end
    end

    exp_t expq[$];
    exp_t mon_e;
    int   stall_cnt, first_dp_cyc, first_ov_cyc, last_col0_cyc, last_out_cyc;
    bit   b2b_mode;

    initial begin
        forever begin
            @(negedge clk);
            if (busy && !dp_rst) stall_cnt++;
            if (dp_rst && first_dp_cyc < 0) first_dp_cyc = cyc;
            if (out_valid) begin
                if (first_ov_cyc < 0) first_ov_cyc = cyc;
                if (expq.size() > 0) begin
                    mon_e = expq.pop_front();
                end else begin
                    mon_e = '1;
                end
                check("out_data", out_data, mon_e.data);
                check("out_col", out_col, mon_e.col);
                check("out_tile", out_tile, mon_e.tile);
                if (out_col == 2'd0) begin
                    if (b2b_mode && out_tile != 0)
                        check("b2b_spacing", cyc - last_col0_cyc, 6);
                    last_col0_cyc = cyc;
                end
                last_out_cyc = cyc;
            end
        end
    end

    task automatic run_job(input int n, input bit ones, input int gap_at, input int gap_len,
                           input int rst_at, input int restart_at, input bit b2b,
                           input int exp_stall);
        logic [4*W-1:0] vecs[$];
        mat_t x, r;
        int   vi, c, gap_left;
        bit   gap_used, done_seen, acc;
        for (int t = 0; t < n; t++) begin
            for (int col = 0; col < 4; col++) begin
                for (int l = 0; l < 4; l++) x[col*4+l] = ones ? 32'd1 : $urandom;
                vecs.push_back({x[col*4+3], x[col*4+2], x[col*4+1], x[col*4+0]});
            end
            r = xform(x);
            for (int j = 0; j < 4; j++)
                expq.push_back('{data: {r[j*4+3], r[j*4+2], r[j*4+1], r[j*4+0]},
                                 col: 2'(j), tile: TCW'(t)});
        end
        stall_cnt     = 0;
        first_dp_cyc  = -1;
        first_ov_cyc  = -1;
        last_col0_cyc = 0;
        b2b_mode      = b2b;
        @(negedge clk);
        start     = 1'b1;
        num_tiles = TCW'(n);
        @(negedge clk);
        start     = 1'b0;
        vi = 0; c = 0; gap_left = 0; gap_used = 0; done_seen = 0;
        while (!done_seen && c < 400) begin
            if (c == rst_at) begin
                #2 rst = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_in_ready", in_ready, 0);
                check("rst_out_valid", out_valid, 0);
                check("rst_out_data", out_data, 0);
                check("rst_out_tile", {out_tile, out_col}, 0);
                check("rst_dp", {dp_rst, dp_x1, dp_x2, dp_x3}, 0);
                expq.delete();
                in_valid = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            start = (c == restart_at);
            if (c == restart_at) num_tiles = TCW'(7);
            if (done) begin
                done_seen = 1;
                check("done_busy_low", busy, 0);
                check("done_after_col3", cyc - last_out_cyc, 1);
            end else begin
                if (vi == gap_at && !gap_used) begin
                    gap_left = gap_len;
                    gap_used = 1;
                end
                if (gap_left > 0) begin
                    in_valid = 1'b0;
                    gap_left--;
                end else if (vi < 4 * n) begin
                    in_valid = 1'b1;
                    in_data  = vecs[vi];
                end else begin
                    in_valid = 1'b0;
                end
                acc = in_valid && in_ready;
                @(posedge clk);
                if (acc) vi++;
                @(negedge clk);
                c++;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("done_seen", done_seen, 1);
        check("accepted", vi, 4 * n);
        check("launch_to_out", first_ov_cyc - first_dp_cyc, 3);
        if (exp_stall >= 0) check("stall_cycles", stall_cnt, exp_stall);
        if (done_seen) begin
            @(negedge clk);
            check("done_pulse_width", done, 0);
            check("queue_drained", expq.size(), 0);
            check("in_ready_idle", in_ready, 0);
        end
        expq.delete();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        num_tiles = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        #2 rst = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_col", out_col, 0);
        check("reset_out_tile", out_tile, 0);
        check("reset_dp_rst", dp_rst, 0);
        check("reset_dp_x", {dp_x4, dp_x3, dp_x2, dp_x1}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Single all-ones tile, then back-to-back and stalled multi-tile jobs.
        run_job(1, 1'b1, -1, 0, -1, -1, 1'b0, 5);
        run_job(3, 1'b0, -1, 0, -1, -1, 1'b1, 5);
        run_job(2, 1'b0, 6, 5, -1, -1, 1'b0, 8);

        // Zero-tile job completes immediately without accepting input.
        @(negedge clk);
        start     = 1'b1;
        num_tiles = '0;
        in_valid  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_in_ready", in_ready, 0);
        @(negedge clk);
        check("zero_done_width", done, 0);
        check("zero_in_ready_after", in_ready, 0);
        check("zero_busy_after", busy, 0);
        in_valid = 1'b0;

        run_job(2, 1'b0, -1, 0, -1, 8, 1'b1, 5);
        run_job(4, 1'b0, -1, 0, 13, -1, 1'b0, -1);
        run_job(1, 1'b0, -1, 0, -1, -1, 1'b0, 5);
        run_job(5, 1'b0, $urandom_range(18, 1), $urandom_range(7, 1), -1, -1, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
